// File: rtl/cfg_write_arbiter_if.sv
// Write-request bundle for the two config-bank requesters (SPI port 0, sequencer port 1).
// The master drives valid/addr/data and holds them until it sees ready.
interface cfg_write_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/cfg_write_arbiter.sv
// Two-port round-robin writer into shadow config regs; shadows are copied to the active
// outputs only on a committed PWM period boundary. Ready is a combinational accept strobe.
module cfg_write_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic               clk,
    input  logic               rst,
    cfg_write_arbiter_if.slave req,
    input  logic               commit_pulse,
    output logic [DATA_W-1:0]  en_reg_out_7_0,
    output logic [DATA_W-1:0]  en_reg_out_15_8,
    output logic [DATA_W-1:0]  en_reg_pwm_7_0,
    output logic [DATA_W-1:0]  en_reg_pwm_15_8,
    output logic [DATA_W-1:0]  pwm_duty_cycle,
    output logic               dirty,
    output logic               addr_err
);
    typedef enum logic [1:0] {IDLE, WR, CMT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rr_last_q, rr_last_d;
    logic              dirty_q, dirty_d;
    logic              commit_pend_q, commit_pend_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] shadow_d [NUM_REGS];
    logic [DATA_W-1:0] active_q [NUM_REGS];
    logic [DATA_W-1:0] active_d [NUM_REGS];
    logic              gnt0, gnt1;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        rr_last_d     = rr_last_q;
        dirty_d       = dirty_q;
        commit_pend_d = commit_pend_q;
        addr_err_d    = 1'b0;
        shadow_d      = shadow_q;
        active_d      = active_q;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        gnt_addr      = req.req0_addr;
        gnt_data      = req.req0_data;

        case (state_q)
            IDLE: begin
                if (commit_pend_q && dirty_q) begin
                    state_d = CMT;
                end else begin
                    commit_pend_d = 1'b0;
                    // rr_last=1 means port 1 won last time, so port 0 takes the tie
                    gnt0 = req.req0_valid && (!req.req1_valid || rr_last_q);
                    gnt1 = req.req1_valid && !gnt0;
                    if (gnt1) begin
                        gnt_addr = req.req1_addr;
                        gnt_data = req.req1_data;
                    end
                    if (gnt0 || gnt1) begin
                        addr_d     = gnt_addr;
                        data_d     = gnt_data;
                        rr_last_d  = gnt1;
                        addr_err_d = (gnt_addr >= ADDR_W'(NUM_REGS));
                        state_d    = WR;
                    end
                end
            end
            WR: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr_q == ADDR_W'(i)) begin
                        shadow_d[i] = data_q;
                        dirty_d     = 1'b1;
                    end
                end
                state_d = IDLE;
            end
            CMT: begin
                active_d      = shadow_q;
                dirty_d       = 1'b0;
                commit_pend_d = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A period-end pulse must never be lost, whatever the FSM is doing
        if (commit_pulse) commit_pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            rr_last_q     <= 1'b1;
            dirty_q       <= 1'b0;
            commit_pend_q <= 1'b0;
            addr_err_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            rr_last_q     <= rr_last_d;
            dirty_q       <= dirty_d;
            commit_pend_q <= commit_pend_d;
            addr_err_q    <= addr_err_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    assign req.req0_ready   = gnt0 && !rst;
    assign req.req1_ready   = gnt1 && !rst;
    assign en_reg_out_7_0   = active_q[0];
    assign en_reg_out_15_8  = active_q[1];
    assign en_reg_pwm_7_0   = active_q[2];
    assign en_reg_pwm_15_8  = active_q[3];
    assign pwm_duty_cycle   = active_q[4];
    assign dirty            = dirty_q;
    assign addr_err         = addr_err_q;
endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Bench for cfg_write_arbiter: per-cycle vector table, directed corner sequences,
// then constrained-random traffic scored against a transaction-level reference model.
module tb_cfg_write_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       commit_pulse;
    logic [7:0] o_out0, o_out1, o_pwm0, o_pwm1, o_duty;
    logic       dirty, addr_err;
    int         errors = 0;
    int         checks = 0;

    cfg_write_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    cfg_write_arbiter #(.ADDR_W(7), .DATA_W(8), .NUM_REGS(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (bus),
        .commit_pulse    (commit_pulse),
        .en_reg_out_7_0  (o_out0),
        .en_reg_out_15_8 (o_out1),
        .en_reg_pwm_7_0  (o_pwm0),
        .en_reg_pwm_15_8 (o_pwm1),
        .pwm_duty_cycle  (o_duty),
        .dirty           (dirty),
        .addr_err        (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] dut_act(input int i);
        case (i)
            0:       return o_out0;
            1:       return o_out1;
            2:       return o_pwm0;
            3:       return o_pwm1;
            default: return o_duty;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = 7'h00; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_addr = 7'h00; bus.req1_data = 8'h00;
        commit_pulse   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v0; logic [6:0] a0; logic [7:0] d0;
        logic       v1; logic [6:0] a1; logic [7:0] d1;
        logic       cp;
        logic       r0, r1, err, dty;
        logic [7:0] duty;
    } vec_t;
    vec_t tbl [16];

    // ---------------- reference model ----------------
    typedef struct { logic [6:0] a; logic [7:0] d; } wr_t;
    logic [7:0] m_sh  [5];
    logic [7:0] m_act [5];
    logic       m_dirty, m_pend, m_cmt;
    int         m_last;
    wr_t        m_wr [$];

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin m_sh[i] = 8'h00; m_act[i] = 8'h00; end
        m_dirty = 1'b0; m_pend = 1'b0; m_cmt = 1'b0; m_last = 1;
        m_wr.delete();
    endtask

    // Compare one cycle at the negedge, then advance the model across the next posedge.
    task automatic model_cycle(output logic r0, output logic r1);
        logic busy, exp_err, v0, v1;
        int   win;
        wr_t  w;
        v0 = bus.req0_valid; v1 = bus.req1_valid;
        busy = (m_wr.size() != 0) || m_cmt || (m_pend && m_dirty);
        win = -1;
        if (!busy) begin
            if (v0 && v1)  win = 1 - m_last;
            else if (v0)   win = 0;
            else if (v1)   win = 1;
        end
        exp_err = (m_wr.size() != 0) && (m_wr[0].a >= 7'd5);
        chk("rnd_ready0", {31'd0, bus.req0_ready}, {31'd0, win == 0});
        chk("rnd_ready1", {31'd0, bus.req1_ready}, {31'd0, win == 1});
        chk("rnd_addr_err", {31'd0, addr_err}, {31'd0, exp_err});
        chk("rnd_dirty", {31'd0, dirty}, {31'd0, m_dirty});
        for (int i = 0; i < 5; i++) chk("rnd_active", {24'd0, dut_act(i)}, {24'd0, m_act[i]});
        r0 = bus.req0_ready; r1 = bus.req1_ready;

        if (m_wr.size() != 0) begin
            w = m_wr.pop_front();
            if (w.a < 7'd5) begin m_sh[w.a[2:0]] = w.d; m_dirty = 1'b1; end
        end else if (m_cmt) begin
            for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
            m_dirty = 1'b0; m_pend = 1'b0; m_cmt = 1'b0;
        end else if (m_pend && m_dirty) begin
            m_cmt = 1'b1;
        end else begin
            m_pend = 1'b0;
            if (win == 0) begin w.a = bus.req0_addr; w.d = bus.req0_data; m_wr.push_back(w); m_last = 0; end
            if (win == 1) begin w.a = bus.req1_addr; w.d = bus.req1_data; m_wr.push_back(w); m_last = 1; end
        end
        if (commit_pulse) m_pend = 1'b1;
    endtask

    task automatic rand_port(input int p, input logic granted);
        logic       v, nv, new_req;
        logic [6:0] a;
        logic [7:0] d;
        v = (p == 0) ? bus.req0_valid : bus.req1_valid;
        nv = v; new_req = 1'b0;
        if (v && granted) begin
            nv = ($urandom_range(0, 1) == 1); new_req = nv;
        end else if (v) begin
            if ($urandom_range(0, 19) == 0) nv = 1'b0;
        end else begin
            nv = ($urandom_range(0, 9) < 4); new_req = nv;
        end
        a = 7'($urandom_range(0, 6));
        d = 8'($urandom);
        if (p == 0) begin
            bus.req0_valid = nv;
            if (new_req) begin bus.req0_addr = a; bus.req0_data = d; end
        end else begin
            bus.req1_valid = nv;
            if (new_req) begin bus.req1_addr = a; bus.req1_data = d; end
        end
    endtask

    initial begin
        int   order [6];
        int   n, cnt0, cnt1;
        logic g0, g1;

        tbl[0]  = '{1'b1, 7'h04, 8'h80, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[4]  = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[5]  = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[6]  = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80};
        tbl[7]  = '{1'b1, 7'h00, 8'h11, 1'b1, 7'h01, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80};
        tbl[8]  = '{1'b1, 7'h00, 8'h11, 1'b1, 7'h01, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80};
        tbl[9]  = '{1'b1, 7'h00, 8'h11, 1'b1, 7'h01, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80};
        tbl[10] = '{1'b1, 7'h00, 8'h11, 1'b1, 7'h01, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80};
        tbl[11] = '{1'b1, 7'h00, 8'h11, 1'b1, 7'h01, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80};
        tbl[12] = '{1'b0, 7'h00, 8'h00, 1'b1, 7'h05, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80};
        tbl[13] = '{1'b0, 7'h00, 8'h00, 1'b1, 7'h05, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80};
        tbl[14] = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80};
        tbl[15] = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80};

        // Reset state, with both requesters asserting to show ready is held low
        idle_inputs();
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_dirty", {31'd0, dirty}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        for (int i = 0; i < 5; i++) chk("rst_active", {24'd0, dut_act(i)}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;

        // Per-cycle vectors: write, commit latency, round-robin tie, invalid address
        for (int i = 0; i < 16; i++) begin
            bus.req0_valid = tbl[i].v0; bus.req0_addr = tbl[i].a0; bus.req0_data = tbl[i].d0;
            bus.req1_valid = tbl[i].v1; bus.req1_addr = tbl[i].a1; bus.req1_data = tbl[i].d1;
            commit_pulse   = tbl[i].cp;
            @(negedge clk);
            chk($sformatf("vec%0d_ready0", i), {31'd0, bus.req0_ready}, {31'd0, tbl[i].r0});
            chk($sformatf("vec%0d_ready1", i), {31'd0, bus.req1_ready}, {31'd0, tbl[i].r1});
            chk($sformatf("vec%0d_addr_err", i), {31'd0, addr_err}, {31'd0, tbl[i].err});
            chk($sformatf("vec%0d_dirty", i), {31'd0, dirty}, {31'd0, tbl[i].dty});
            chk($sformatf("vec%0d_duty", i), {24'd0, o_duty}, {24'd0, tbl[i].duty});
            next_cycle();
        end
        idle_inputs();
        chk("vec_reg0_uncommitted", {24'd0, o_out0}, 32'd0);

        // Both ports held valid from reset: grants alternate starting with port 0
        do_reset();
        for (int k = 0; k < 6; k++) order[k] = 9;
        n = 0; cnt0 = 0; cnt1 = 0;
        bus.req0_valid = 1'b1; bus.req0_addr = 7'h00; bus.req0_data = 8'h11;
        bus.req1_valid = 1'b1; bus.req1_addr = 7'h01; bus.req1_data = 8'h22;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (bus.req0_ready && n < 6) begin order[n] = 0; n++; cnt0++; end
            if (bus.req1_ready && n < 6) begin order[n] = 1; n++; cnt1++; end
            next_cycle();
            if (cnt0 >= 3) bus.req0_valid = 1'b0;
            if (cnt1 >= 3) bus.req1_valid = 1'b0;
        end
        idle_inputs();
        chk("rr_grant_count", n, 6);
        for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), order[k], k % 2);
        commit_pulse = 1'b1;
        next_cycle();
        commit_pulse = 1'b0;
        repeat (5) next_cycle();
        chk("rr_out0", {24'd0, o_out0}, 32'h11);
        chk("rr_out1", {24'd0, o_out1}, 32'h22);
        chk("rr_dirty", {31'd0, dirty}, 32'd0);

        // Commit pulse in the same cycle as a grant: the write rides along in that commit
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 7'h02; bus.req0_data = 8'h5A;
        commit_pulse = 1'b1;
        @(negedge clk);
        chk("cogrant_ready0", {31'd0, bus.req0_ready}, 32'd1);
        next_cycle();
        idle_inputs();
        repeat (2) next_cycle();
        chk("cogrant_pwm0_early", {24'd0, o_pwm0}, 32'h00);
        chk("cogrant_dirty_early", {31'd0, dirty}, 32'd1);
        next_cycle();
        chk("cogrant_pwm0", {24'd0, o_pwm0}, 32'h5A);
        chk("cogrant_dirty", {31'd0, dirty}, 32'd0);

        // Commit while clean is a no-op and leaves nothing pending
        commit_pulse = 1'b1;
        next_cycle();
        commit_pulse = 1'b0;
        repeat (4) next_cycle();
        chk("clean_commit_dirty", {31'd0, dirty}, 32'd0);
        chk("clean_commit_pwm0", {24'd0, o_pwm0}, 32'h5A);
        bus.req0_valid = 1'b1; bus.req0_addr = 7'h03; bus.req0_data = 8'h77;
        @(negedge clk);
        chk("clean_wr_ready0", {31'd0, bus.req0_ready}, 32'd1);
        next_cycle();
        idle_inputs();
        repeat (6) next_cycle();
        chk("clean_no_stale_pwm1", {24'd0, o_pwm1}, 32'h00);
        chk("clean_wr_dirty", {31'd0, dirty}, 32'd1);

        // Reset while a granted write is in flight and a commit is pending
        bus.req0_valid = 1'b1; bus.req0_addr = 7'h03; bus.req0_data = 8'h99;
        commit_pulse = 1'b1;
        @(negedge clk);
        chk("midrst_ready0", {31'd0, bus.req0_ready}, 32'd1);
        next_cycle();
        commit_pulse = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready0_held", {31'd0, bus.req0_ready}, 32'd0);
        chk("midrst_dirty", {31'd0, dirty}, 32'd0);
        for (int i = 0; i < 5; i++) chk("midrst_active", {24'd0, dut_act(i)}, 32'd0);
        next_cycle();
        idle_inputs();
        rst = 1'b0;
        repeat (6) next_cycle();
        chk("postrst_pwm1", {24'd0, o_pwm1}, 32'h00);
        chk("postrst_dirty", {31'd0, dirty}, 32'd0);
        chk("postrst_addr_err", {31'd0, addr_err}, 32'd0);

        // Random traffic against the reference model
        do_reset();
        model_reset();
        g0 = 1'b0; g1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rand_port(0, g0);
            rand_port(1, g1);
            commit_pulse = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            model_cycle(g0, g1);
            next_cycle();
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
